// File: rtl/cam_pkg.sv
// Shared constants for the camera point filter: camera and screen geometry,
// the no-blob marker and the camera-to-screen scale factor (5/8).
package cam_pkg;

  localparam int          CAM_W       = 1024;
  localparam int          CAM_H       = 768;
  localparam logic [9:0]  CAM_NO_BLOB = 10'h3FF;

  localparam int          SCREEN_W    = 640;
  localparam int          SCREEN_H    = 480;

  localparam int          SCALE_NUM   = 5;
  localparam int          SCALE_SHIFT = 3;

endpackage

// File: rtl/cam_point_filter_pos_avg.sv
// Single-axis boxcar average: history shift register plus running sum.
// Preload fills the whole window with one sample so a new stroke starts clean.
module pos_avg #(
  parameter int AVG_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic                  preload_i,
  input  logic [9:0]            sample_i,
  output logic [9+AVG_LOG2:0]   sum_o
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = 10 + AVG_LOG2;

  logic [9:0]       hist_q [DEPTH];
  logic [9:0]       hist_d [DEPTH];
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;

  always_comb begin
    hist_d = hist_q;
    sum_d  = sum_q;
    if (en_i) begin
      if (preload_i) begin
        for (int i = 0; i < DEPTH; i++) hist_d[i] = sample_i;
        sum_d = SUM_W'(sample_i) << AVG_LOG2;
      end else begin
        hist_d[0] = sample_i;
        for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
        // sum always contains the oldest entry, so the subtraction cannot wrap
        sum_d = sum_q + SUM_W'(sample_i) - SUM_W'(hist_q[DEPTH-1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      sum_q <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/cam_point_filter.sv
// IR-blob point filter: validates camera samples, tracks pen up/down, boxcar
// smooths, scales to 640x480 and emits draw requests. Build option: CAM_MIRROR_X_EN.
module cam_point_filter
  import cam_pkg::*;
#(
  parameter int AVG_LOG2     = 2,
  parameter int LIFT_SAMPLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(CAM_W)-1:0]      cam_x,
  input  logic [$clog2(CAM_W)-1:0]      cam_y,
  input  logic                          sample_stb,
  output logic                          draw_valid,
  input  logic                          draw_ready,
  output logic [$clog2(SCREEN_W)-1:0]   draw_x,
  output logic [$clog2(SCREEN_H)-1:0]   draw_y,
  output logic                          pen_down,
  output logic [7:0]                    drop_count
);

  localparam int         SUM_W     = 10 + AVG_LOG2;
  localparam int         SCALE_SHL = $clog2(SCALE_NUM) - 1;
  localparam logic [9:0] CAM_Y_MAX = 10'(CAM_H - 1);
  localparam logic [3:0] LIFT_N    = 4'(LIFT_SAMPLES);

  // avg * 5 / 8 as shift-and-add; 1023*5 fits in 13 bits
  function automatic logic [9:0] scale_5_8(input logic [9:0] avg);
    logic [12:0] prod;
    prod = (13'(avg) << SCALE_SHL) + 13'(avg);
    return 10'(prod >> SCALE_SHIFT);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---- stage 1: capture and validate ----
  logic [9:0] cam_x_p1_q, cam_y_p1_q;
  logic       vld_p1_q, ok_p1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= sample_stb;
    end
    cam_x_p1_q <= cam_x;
    cam_y_p1_q <= cam_y;
    ok_p1_q    <= (cam_x != CAM_NO_BLOB) && (cam_y != CAM_NO_BLOB) && (cam_y <= CAM_Y_MAX);
  end

  // ---- stage 2: pen tracking and boxcar ----
  logic       accept_p1;
  logic       pen_q, pen_d;
  logic [3:0] miss_q, miss_d;
  logic       vld_p2_q;
  logic [SUM_W-1:0] sum_x_p2, sum_y_p2;

  assign accept_p1 = vld_p1_q && ok_p1_q;

  always_comb begin
    pen_d  = pen_q;
    miss_d = miss_q;
    if (vld_p1_q) begin
      if (ok_p1_q) begin
        miss_d = '0;
        pen_d  = 1'b1;
      end else if (miss_q < LIFT_N) begin
        miss_d = miss_q + 4'd1;
        if (miss_d == LIFT_N) pen_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pen_q    <= 1'b0;
      miss_q   <= '0;
      vld_p2_q <= 1'b0;
    end else begin
      pen_q    <= pen_d;
      miss_q   <= miss_d;
      vld_p2_q <= accept_p1;
    end
  end

  pos_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_x (
    .clk       (clk),
    .reset     (reset),
    .en_i      (accept_p1),
    .preload_i (!pen_q),
    .sample_i  (cam_x_p1_q),
    .sum_o     (sum_x_p2)
  );

  pos_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_y (
    .clk       (clk),
    .reset     (reset),
    .en_i      (accept_p1),
    .preload_i (!pen_q),
    .sample_i  (cam_y_p1_q),
    .sum_o     (sum_y_p2)
  );

  // ---- stage 3: scale into screen space ----
  logic [9:0] scaled_x_p2, scaled_y_p2;
  logic [9:0] res_x_p2;
  logic [8:0] res_y_p2;

  assign scaled_x_p2 = scale_5_8(10'(sum_x_p2 >> AVG_LOG2));
  assign scaled_y_p2 = scale_5_8(10'(sum_y_p2 >> AVG_LOG2));
`ifdef CAM_MIRROR_X_EN
  assign res_x_p2 = 10'(SCREEN_W - 1) - scaled_x_p2;
`else
  assign res_x_p2 = scaled_x_p2;
`endif
  assign res_y_p2 = 9'(scaled_y_p2);

  // ---- output register and handshake ----
  logic       draw_valid_q, draw_valid_d;
  logic [9:0] draw_x_q, draw_x_d;
  logic [8:0] draw_y_q, draw_y_d;
  logic [7:0] drop_q, drop_d;

  always_comb begin
    draw_valid_d = draw_valid_q;
    draw_x_d     = draw_x_q;
    draw_y_d     = draw_y_q;
    drop_d       = drop_q;
    if (vld_p2_q) begin
      draw_valid_d = 1'b1;
      draw_x_d     = res_x_p2;
      draw_y_d     = res_y_p2;
      // latest wins; only an un-accepted overwrite counts as a drop
      if (draw_valid_q && !draw_ready) drop_d = sat_inc8(drop_q);
    end else if (draw_valid_q && draw_ready) begin
      draw_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      draw_valid_q <= 1'b0;
      draw_x_q     <= '0;
      draw_y_q     <= '0;
      drop_q       <= '0;
    end else begin
      draw_valid_q <= draw_valid_d;
      draw_x_q     <= draw_x_d;
      draw_y_q     <= draw_y_d;
      drop_q       <= drop_d;
    end
  end

  assign draw_valid = draw_valid_q;
  assign draw_x     = draw_x_q;
  assign draw_y     = draw_y_q;
  assign pen_down   = pen_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_cam_point_filter.sv
// Scoreboard bench for cam_point_filter: a behavioural model queues expected
// draw requests when samples are driven; a negedge monitor checks the handshake.
module tb_cam_point_filter;

  localparam int AVG   = 2;
  localparam int LIFT  = 4;
  localparam int DEPTH = 1 << AVG;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] cam_x = '0;
  logic [9:0] cam_y = '0;
  logic       sample_stb = 1'b0;
  logic       draw_valid;
  logic       draw_ready = 1'b0;
  logic [9:0] draw_x;
  logic [8:0] draw_y;
  logic       pen_down;
  logic [7:0] drop_count;

  cam_point_filter #(.AVG_LOG2(AVG), .LIFT_SAMPLES(LIFT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cam_x      (cam_x),
    .cam_y      (cam_y),
    .sample_stb (sample_stb),
    .draw_valid (draw_valid),
    .draw_ready (draw_ready),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .pen_down   (pen_down),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int x;
    int y;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   hx[DEPTH];
  int   hy[DEPTH];
  int   m_pen, m_miss, m_pend, m_drops;
  int   last_x = -1, last_y = -1;
  bit   mon_en = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int scale58(input int avg);
    return (avg * 5) / 8;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_pen = 0; m_miss = 0; m_pend = 0; m_drops = 0;
    for (int i = 0; i < DEPTH; i++) begin hx[i] = 0; hy[i] = 0; end
  endtask

  task automatic model_push(input int x, input int y);
    int sx, sy, ex, ey;
    exp_t e;
    if (x == 1023 || y == 1023 || y > 767) begin
      if (m_miss < LIFT) m_miss++;
      if (m_miss == LIFT) m_pen = 0;
      return;
    end
    m_miss = 0;
    if (m_pen == 0) begin
      for (int i = 0; i < DEPTH; i++) begin hx[i] = x; hy[i] = y; end
      m_pen = 1;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin hx[i] = hx[i-1]; hy[i] = hy[i-1]; end
      hx[0] = x; hy[0] = y;
    end
    sx = 0; sy = 0;
    for (int i = 0; i < DEPTH; i++) begin sx += hx[i]; sy += hy[i]; end
    ex = scale58(sx / DEPTH);
    ey = scale58(sy / DEPTH);
`ifdef CAM_MIRROR_X_EN
    ex = 639 - ex;
`endif
    e.due = cyc + 3; e.x = ex; e.y = ey;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input int x, input int y);
    cam_x = 10'(x); cam_y = 10'(y); sample_stb = 1'b1;
    model_push(x, y);
    @(posedge clk); #1;
    sample_stb = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset = 1'b1;
    model_reset();
    idle(2);
    reset = 1'b0;
    idle(1);
    mon_en = 1'b1;
  endtask

  task automatic lift();
    drive(1023, 1023); drive(1023, 5); drive(5, 1023); drive(5, 800);
    idle(2);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: model of draw_valid / drop_count and coordinate comparison
  initial forever begin
    bit arrived;
    @(negedge clk);
    if (mon_en) begin
      arrived = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        cur = sb.pop_front();
        arrived = 1'b1;
      end
      if (arrived) begin
        if (m_pend != 0 && m_drops < 255) m_drops++;
        m_pend = 1;
      end
      check("draw_valid", int'(draw_valid), m_pend);
      if (m_pend != 0) begin
        check("draw_x", int'(draw_x), cur.x);
        check("draw_y", int'(draw_y), cur.y);
      end
      check("drop_count", int'(drop_count), m_drops);
      if (m_pend != 0 && draw_ready) begin
        last_x = int'(draw_x);
        last_y = int'(draw_y);
        m_pend = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    model_reset();
    idle(1);
    do_reset();
    check("rst_valid", int'(draw_valid), 0);
    check("rst_x", int'(draw_x), 0);
    check("rst_y", int'(draw_y), 0);
    check("rst_pen", int'(pen_down), 0);
    check("rst_drop", int'(drop_count), 0);

    // first sample, idle output
    draw_ready = 1'b1;
    drive(512, 384);
    idle(5);
    check("t1_pen", int'(pen_down), 1);
    check("t1_x", last_x, 320);
    check("t1_y", last_y, 240);

    // pen lift timing, then fresh stroke without history
    drive(1023, 1023); drive(1023, 1023); drive(1023, 1023);
    idle(2);
    check("pen_hold3", int'(pen_down), 1);
    drive(1023, 1023);
    idle(2);
    check("pen_lift4", int'(pen_down), 0);
    drive(100, 100);
    idle(5);
    check("fresh_x", last_x, 62);
    check("fresh_y", last_y, 62);

    // preload then boxcar
    lift();
    check("lift_pen", int'(pen_down), 0);
    drive(0, 0); drive(0, 0); drive(0, 0); drive(0, 0); drive(800, 400);
    idle(5);
    check("box_x", last_x, 125);
    check("box_y", last_y, 62);

    // backpressure: latest wins, two drops
    d0 = m_drops;
    draw_ready = 1'b0;
    drive(200, 100); drive(300, 200); drive(400, 300);
    idle(5);
    check("bp_valid", int'(draw_valid), 1);
    check("bp_drop", int'(drop_count), d0 + 2);
    draw_ready = 1'b1;
    idle(2);
    check("bp_accept", int'(draw_valid), 0);

    // accept on the same cycle a new result loads
    drive(600, 500); drive(610, 510);
    idle(5);

    // edge values
    lift();
    drive(1022, 767);
    idle(5);
`ifdef CAM_MIRROR_X_EN
    check("edge_x", last_x, 1);
`else
    check("edge_x", last_x, 638);
`endif
    check("edge_y", last_y, 479);
    lift();
    drive(0, 0);
    idle(5);
`ifdef CAM_MIRROR_X_EN
    check("zero_x", last_x, 639);
`else
    check("zero_x", last_x, 0);
`endif
    check("zero_y", last_y, 0);

    // random burst with random ready
    repeat (60) begin
      draw_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) drive(1023, int'($urandom_range(0, 767)));
      else drive(int'($urandom_range(0, 1022)), int'($urandom_range(0, 767)));
    end
    draw_ready = 1'b1;
    idle(5);

    // drop counter saturation
    draw_ready = 1'b0;
    repeat (262) drive(int'($urandom_range(0, 1022)), int'($urandom_range(0, 767)));
    idle(5);
    check("drop_sat", int'(drop_count), 255);
    draw_ready = 1'b1;
    idle(3);

    // reset with a sample in flight
    drive(300, 300);
    mon_en = 1'b0;
    reset = 1'b1;
    model_reset();
    idle(1);
    reset = 1'b0;
    mon_en = 1'b1;
    idle(6);
    check("midrst_valid", int'(draw_valid), 0);
    check("midrst_pen", int'(pen_down), 0);
    check("midrst_drop", int'(drop_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
